// File: rtl/hdc_ngram_encoder.sv
// hdc_ngram_encoder: hyperdimensional trigram encoder for a character stream.
// Each accepted character is combined with the two before it into a trigram
// hypervector. Every trigram is added into per-bit saturating counters. When
// the message ends, a majority threshold turns the counters into the query
// hypervector.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start                  opens a new message (honoured only in IDLE)
//   in_valid/in_ready      character handshake; in_char, in_last qualify it
//   out_valid/out_ready    result handshake; out_hv, out_count are held in DONE
module hdc_ngram_encoder #(
  parameter int unsigned     D    = 256,
  parameter logic [D-1:0]    SEED = 256'hA5C3_96F0_1E2D_7B48_C0FF_EE11_2233_4455_6677_8899_AABB_CCDD_EEFF_0123_4567_89AB
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_char,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [D-1:0] out_hv,
  output logic [7:0]   out_count
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  typedef enum logic [1:0] {IDLE, ACCUM, THRESH, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q [D];
  logic [CW-1:0]   cnt_d [D];
  logic [CW-1:0]   ngram_q, ngram_d;
  logic [7:0]      h1_q, h1_d, h2_q, h2_d;
  logic [1:0]      nchar_q, nchar_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [D-1:0]    out_hv_q, out_hv_d;
  logic [CW-1:0]   out_count_q, out_count_d;
  logic [D-1:0]    trig;
  logic            accept;

  // Rotate left by k mod D: take the upper half of the doubled vector.
  function automatic logic [D-1:0] rotl(input logic [D-1:0] x, input int unsigned k);
    logic [2*D-1:0] t;
    t = {x, x} << (k % D);
    return t[2*D-1 -: D];
  endfunction

  // Trigram of (h2, h1, current char); the nested rotations fold into one offset.
  assign trig   = rotl(SEED, 32'(h2_q) + 32'd2) ^
                  rotl(SEED, 32'(h1_q) + 32'd1) ^
                  rotl(SEED, 32'(in_char));
  assign accept = in_valid && in_ready_q;

  // Next-state and datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ngram_d     = ngram_q;
    h1_d        = h1_q;
    h2_d        = h2_q;
    nchar_d     = nchar_q;
    out_valid_d = 1'b0;
    out_hv_d    = out_hv_q;
    out_count_d = out_count_q;
    in_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 0; i < D; i++) cnt_d[i] = '0;
          ngram_d = '0;
          h1_d    = '0;
          h2_d    = '0;
          nchar_d = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          h2_d = h1_q;
          h1_d = in_char;
          if (nchar_q == 2'd2) begin
            for (int i = 0; i < D; i++) begin
              if (trig[i] && (cnt_q[i] != CMAX)) cnt_d[i] = cnt_q[i] + 8'd1;
            end
            if (ngram_q != CMAX) ngram_d = ngram_q + 8'd1;
          end else begin
            nchar_d = nchar_q + 2'd1;
          end
          if (in_last) state_d = THRESH;
        end
      end
      THRESH: begin
        // Strict majority: ties resolve to 0.
        for (int i = 0; i < D; i++) begin
          out_hv_d[i] = ({cnt_q[i], 1'b0} > {1'b0, ngram_q});
        end
        out_count_d = ngram_q;
        state_d     = DONE;
      end
      DONE: begin
        // out_valid rises one cycle after entering DONE and drops after the handshake.
        if (out_valid_q && out_ready) state_d = IDLE;
        else                          out_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == ACCUM);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      for (int i = 0; i < D; i++) cnt_q[i] <= '0;
      ngram_q     <= '0;
      h1_q        <= '0;
      h2_q        <= '0;
      nchar_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_hv_q    <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < D; i++) cnt_q[i] <= cnt_d[i];
      ngram_q     <= ngram_d;
      h1_q        <= h1_d;
      h2_q        <= h2_d;
      nchar_q     <= nchar_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_hv_q    <= out_hv_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_hv    = out_hv_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_hdc_ngram_encoder.sv
// Self-checking bench for hdc_ngram_encoder: directed scenarios plus random
// messages compared against a bit-level reference model.
module tb_hdc_ngram_encoder;

  localparam int unsigned D = 256;
  localparam logic [D-1:0] SEED = 256'hA5C3_96F0_1E2D_7B48_C0FF_EE11_2233_4455_6677_8899_AABB_CCDD_EEFF_0123_4567_89AB;

  typedef byte unsigned msg_t[$];

  logic         clk = 1'b0;
  logic         reset, start, in_valid, in_last, out_ready;
  logic         in_ready, out_valid;
  logic [7:0]   in_char, out_count;
  logic [D-1:0] out_hv;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hdc_ngram_encoder #(.D(D), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hv(out_hv), .out_count(out_count)
  );

  // Reference rotation straight from the definition: bit i moves to (i+k) mod D.
  function automatic logic [D-1:0] rotl_m(input logic [D-1:0] x, input int unsigned k);
    logic [D-1:0] r;
    int idx;
    for (int i = 0; i < D; i++) begin
      idx = int'((i + k) % D);
      r[idx] = x[i];
    end
    return r;
  endfunction

  // Reference encoder over a whole message.
  function automatic void model(input msg_t m, output logic [D-1:0] hv, output logic [7:0] n);
    int cnt[D];
    int nn;
    logic [D-1:0] t;
    nn = 0;
    for (int i = 0; i < D; i++) cnt[i] = 0;
    for (int j = 2; j < m.size(); j++) begin
      t = rotl_m(rotl_m(SEED, m[j-2]), 2) ^ rotl_m(rotl_m(SEED, m[j-1]), 1) ^ rotl_m(SEED, m[j]);
      for (int i = 0; i < D; i++) if (t[i] && cnt[i] < 255) cnt[i]++;
      if (nn < 255) nn++;
    end
    for (int i = 0; i < D; i++) hv[i] = (2 * cnt[i] > nn);
    n = 8'(nn);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_char(input byte unsigned c, input bit last, output bit to);
    int w;
    w = 0;
    to = 1'b0;
    in_valid = 1'b1; in_char = c; in_last = last;
    while (in_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    if (in_ready !== 1'b1) to = 1'b1;
    else begin @(posedge clk); #1; end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input msg_t m, input int gap, output bit to);
    bit t1;
    to = 1'b0;
    for (int j = 0; j < m.size(); j++) begin
      send_char(m[j], j == m.size() - 1, t1);
      to |= t1;
      repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic get_result(input int hold, output logic [D-1:0] hv, output logic [7:0] cnt,
                            output bit to, output bit stable, output logic valid_after);
    int w;
    w = 0; to = 1'b0; stable = 1'b1;
    out_ready = (hold == 0);
    while (out_valid !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    if (out_valid !== 1'b1) begin
      to = 1'b1; out_ready = 1'b0; valid_after = 1'b0; hv = '0; cnt = '0;
      return;
    end
    hv = out_hv; cnt = out_count;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_hv !== hv || out_count !== cnt || in_ready !== 1'b0) stable = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    valid_after = out_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_char = '0; out_ready = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (out_hv !== '0) begin failures++; $display("FAIL reset_out_hv: got %h exp 0", out_hv); end
    checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL reset_out_count: got %0d exp 0", out_count); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL idle_in_ready: got %b exp 0", in_ready); end
  endtask

  task automatic test_abc_latency();
    bit to, t1;
    out_ready = 1'b1;
    pulse_start();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL accum_in_ready: got %b exp 1", in_ready); end
    send_char(8'd97, 1'b0, to);
    send_char(8'd98, 1'b0, t1); to |= t1;
    send_char(8'd99, 1'b1, t1); to |= t1;
    checks++; if (to) begin failures++; $display("FAIL abc_send: got timeout exp accepted"); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abc_lat_n: got %b exp 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abc_lat_n1: got %b exp 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL abc_lat_n2: got %b exp 1", out_valid); end
    checks++; if (out_hv !== rotl_m(SEED, 99)) begin failures++; $display("FAIL abc_hv: got %h exp %h", out_hv, rotl_m(SEED, 99)); end
    checks++; if (out_count !== 8'd1) begin failures++; $display("FAIL abc_count: got %0d exp 1", out_count); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abc_release: got %b exp 0", out_valid); end
  endtask

  task automatic test_abcd();
    msg_t m; bit to, st; logic va; logic [D-1:0] hv, exp_hv; logic [7:0] cnt;
    m.push_back(8'd97); m.push_back(8'd98); m.push_back(8'd99); m.push_back(8'd100);
    exp_hv = rotl_m(SEED, 99) & rotl_m(SEED, 100);
    pulse_start();
    send_msg(m, 0, to);
    get_result(0, hv, cnt, to, st, va);
    checks++; if (to) begin failures++; $display("FAIL abcd_timeout: got no out_valid exp out_valid"); end
    checks++; if (hv !== exp_hv) begin failures++; $display("FAIL abcd_hv: got %h exp %h", hv, exp_hv); end
    checks++; if (cnt !== 8'd2) begin failures++; $display("FAIL abcd_count: got %0d exp 2", cnt); end
  endtask

  task automatic test_short();
    msg_t m; bit to, st; logic va; logic [D-1:0] hv; logic [7:0] cnt;
    m.push_back(8'd97); m.push_back(8'd98);
    pulse_start();
    send_msg(m, 0, to);
    get_result(0, hv, cnt, to, st, va);
    checks++; if (to) begin failures++; $display("FAIL ab_valid: got no out_valid exp out_valid"); end
    checks++; if (hv !== '0) begin failures++; $display("FAIL ab_hv: got %h exp 0", hv); end
    checks++; if (cnt !== 8'd0) begin failures++; $display("FAIL ab_count: got %0d exp 0", cnt); end
  endtask

  task automatic test_stall();
    msg_t m; bit to, st; logic va; logic [D-1:0] hv; logic [7:0] cnt;
    bit t1;
    m.push_back(8'd97); m.push_back(8'd98); m.push_back(8'd99);
    pulse_start();
    to = 1'b0;
    for (int j = 0; j < 3; j++) begin
      send_char(m[j], j == 2, t1); to |= t1;
      @(posedge clk); #1;
    end
    checks++; if (to) begin failures++; $display("FAIL stall_send: got timeout exp accepted"); end
    get_result(5, hv, cnt, to, st, va);
    checks++; if (to) begin failures++; $display("FAIL stall_timeout: got no out_valid exp out_valid"); end
    checks++; if (hv !== rotl_m(SEED, 99)) begin failures++; $display("FAIL stall_hv: got %h exp %h", hv, rotl_m(SEED, 99)); end
    checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL stall_count: got %0d exp 1", cnt); end
    checks++; if (!st) begin failures++; $display("FAIL stall_hold: got unstable exp stable"); end
    checks++; if (va !== 1'b0) begin failures++; $display("FAIL stall_release: got %b exp 0", va); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_idle: got %b exp 0", in_ready); end
  endtask

  task automatic test_reset_mid();
    msg_t m; bit to, st; logic va; logic [D-1:0] hv; logic [7:0] cnt;
    int w;
    pulse_start();
    send_char(8'd97, 1'b0, to);
    send_char(8'd98, 1'b0, to);
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_in_ready: got %b exp 0", in_ready); end
    checks++; if (out_count !== 8'd0) begin failures++; $display("FAIL rstmid_out_count: got %0d exp 0", out_count); end
    @(posedge clk); #1;
    reset = 1'b0;
    m.push_back(8'd97); m.push_back(8'd98); m.push_back(8'd99);
    pulse_start();
    send_msg(m, 0, to);
    get_result(0, hv, cnt, to, st, va);
    checks++; if (hv !== rotl_m(SEED, 99)) begin failures++; $display("FAIL rstmid_hv: got %h exp %h", hv, rotl_m(SEED, 99)); end
    checks++; if (cnt !== 8'd1) begin failures++; $display("FAIL rstmid_count: got %0d exp 1", cnt); end
    // Reset while a result is waiting in DONE.
    pulse_start();
    send_msg(m, 0, to);
    w = 0;
    while (out_valid !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_hv !== '0) begin failures++; $display("FAIL rstdone_out: got valid=%b hv=%h exp 0", out_valid, out_hv); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL rstdone_idle: got valid=%b ready=%b exp 0 0", out_valid, in_ready); end
  endtask

  task automatic test_long_a();
    bit to, t1, st; logic va; logic [D-1:0] hv, exp_hv; logic [7:0] cnt;
    exp_hv = rotl_m(SEED, 99) ^ rotl_m(SEED, 98) ^ rotl_m(SEED, 97);
    pulse_start();
    to = 1'b0;
    for (int j = 0; j < 200; j++) begin
      if (j == 100) pulse_start();
      send_char(8'd97, j == 199, t1); to |= t1;
    end
    get_result(0, hv, cnt, t1, st, va);
    checks++; if (to || t1) begin failures++; $display("FAIL long_timeout: got timeout exp handshake"); end
    checks++; if (cnt !== 8'd198) begin failures++; $display("FAIL long_count: got %0d exp 198", cnt); end
    checks++; if (hv !== exp_hv) begin failures++; $display("FAIL long_hv: got %h exp %h", hv, exp_hv); end
  endtask

  task automatic test_ignore_idle();
    msg_t m; bit to, st; logic va; logic [D-1:0] hv, exp_hv; logic [7:0] cnt, exp_cnt;
    in_valid = 1'b1; in_last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_char = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL ignore_idle: got ready=%b valid=%b exp 0 0", in_ready, out_valid); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    for (int j = 0; j < 6; j++) m.push_back(8'($urandom_range(0, 255)));
    model(m, exp_hv, exp_cnt);
    pulse_start();
    send_msg(m, 0, to);
    get_result(0, hv, cnt, to, st, va);
    checks++; if (hv !== exp_hv || cnt !== exp_cnt) begin failures++; $display("FAIL ignore_result: got %h/%0d exp %h/%0d", hv, cnt, exp_hv, exp_cnt); end
  endtask

  task automatic test_random();
    msg_t m; bit to, t1, st; logic va; logic [D-1:0] hv, exp_hv; logic [7:0] cnt, exp_cnt;
    for (int r = 0; r < 12; r++) begin
      m.delete();
      for (int j = 0; j < $urandom_range(1, 24); j++) m.push_back(8'($urandom_range(0, 255)));
      model(m, exp_hv, exp_cnt);
      pulse_start();
      send_msg(m, 2, to);
      get_result($urandom_range(0, 3), hv, cnt, t1, st, va);
      checks++; if (to || t1) begin failures++; $display("FAIL rand%0d_timeout: got timeout exp handshake", r); end
      checks++; if (hv !== exp_hv) begin failures++; $display("FAIL rand%0d_hv: got %h exp %h", r, hv, exp_hv); end
      checks++; if (cnt !== exp_cnt) begin failures++; $display("FAIL rand%0d_count: got %0d exp %0d", r, cnt, exp_cnt); end
      checks++; if (!st || va !== 1'b0) begin failures++; $display("FAIL rand%0d_hold: got stable=%b after=%b exp 1 0", r, st, va); end
    end
  endtask

  task automatic test_saturation();
    msg_t m; bit to, t1, st; logic va; logic [D-1:0] hv, exp_hv; logic [7:0] cnt, exp_cnt;
    for (int j = 0; j < 300; j++) m.push_back(8'($urandom_range(0, 7)));
    model(m, exp_hv, exp_cnt);
    pulse_start();
    send_msg(m, 0, to);
    get_result(0, hv, cnt, t1, st, va);
    checks++; if (cnt !== 8'd255) begin failures++; $display("FAIL sat_count: got %0d exp 255", cnt); end
    checks++; if (hv !== exp_hv || to || t1) begin failures++; $display("FAIL sat_hv: got %h exp %h", hv, exp_hv); end
  endtask

  initial begin
    test_reset();
    test_abc_latency();
    test_abcd();
    test_short();
    test_stall();
    test_reset_mid();
    test_long_a();
    test_ignore_idle();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hdc_ngram_encoder.md
HDC_NGRAM_ENCODER -- requirements
Module: hdc_ngram_encoder

Interface
REQ-001 The block SHALL have parameter D, default 256, meaning hypervector dimension in bits.
REQ-002 The block SHALL have parameter SEED, default 256'hA5C3_96F0_1E2D_7B48_C0FF_EE11_2233_4455_6677_8899_AABB_CCDD_EEFF_0123_4567_89AB, meaning the base item hypervector.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1, meaning a one-cycle pulse that opens a new message.
REQ-006 The block SHALL have port in_valid, input, 1, meaning in_char and in_last are valid.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts a character this cycle.
REQ-008 The block SHALL have port in_char, input, 8, meaning one message character (ASCII).
REQ-009 The block SHALL have port in_last, input, 1, meaning this character is the last of the message.
REQ-010 The block SHALL have port out_valid, output, 1, meaning out_hv and out_count are valid.
REQ-011 The block SHALL have port out_ready, input, 1, meaning the downstream classifier consumes the result.
REQ-012 The block SHALL have port out_hv, output, D, meaning the query hypervector for the classifier.
REQ-013 The block SHALL have port out_count, output, 8, meaning the number of trigrams bundled.

Function
REQ-014 Item HV SHALL be IM(c) = rotl(SEED, c), where rotl(x,k) moves bit i to bit (i+k) mod D.
REQ-015 The block SHALL keep a two-character history: h1 is the previous character and h2 is the one before it.
REQ-016 For each accepted character c with at least 2 prior characters in the message, the trigram SHALL be T = rotl(IM(h2),2) ^ rotl(IM(h1),1) ^ IM(c).
REQ-017 For each trigram, every bit counter cnt[i] (8 bits, D counters) SHALL increment where T[i]=1, and ngram_n SHALL increment by 1.
REQ-018 cnt[i] and ngram_n SHALL saturate at 255.
REQ-019 The FSM SHALL have states IDLE, ACCUM, THRESH and DONE.
REQ-020 In IDLE, start=1 SHALL clear all counters, the history and the char count, and move the FSM to ACCUM.
REQ-021 start SHALL be ignored in all states other than IDLE.
REQ-022 in_ready SHALL be 1 only in ACCUM; a character is accepted on a cycle with in_valid & in_ready.
REQ-023 Accepting a character with in_last=1 SHALL include that character's trigram, then move the FSM to THRESH.
REQ-024 In THRESH, out_hv[i] SHALL be registered as 1 iff 2*cnt[i] > ngram_n, so ties give 0; out_count SHALL be registered as ngram_n; the FSM then moves to DONE.
REQ-025 A message of fewer than 3 characters SHALL yield out_hv = 0 and out_count = 0.
REQ-026 In DONE, out_valid SHALL be 1, and out_hv and out_count SHALL be held stable until out_valid & out_ready, after which the FSM returns to IDLE with out_valid=0 on the next cycle.
REQ-027 Latency: if in_last is accepted at edge N, out_valid SHALL rise at edge N+2.
REQ-028 The next start SHALL be honoured no earlier than the first cycle in IDLE.
REQ-029 in_valid while the FSM is not in ACCUM SHALL be ignored and SHALL NOT alter state.

Reset
REQ-030 While reset=1, asynchronously: state SHALL be IDLE; in_ready, out_valid, out_hv, out_count, counters and history SHALL all be 0.
REQ-031 Reset asserted mid-message or in DONE SHALL abort the message with no output, and the first cycle after deassertion SHALL behave as IDLE.

Verification
REQ-032 The bench SHALL cover: start, stream "abc" with in_last on 'c', out_ready=1 -> out_hv = rotl(SEED,99), out_count = 1, out_valid two edges after 'c' is accepted.
REQ-033 The bench SHALL cover: stream "abcd" -> out_count = 2, out_hv = rotl(SEED,99) & rotl(SEED,100), confirming ties resolve to 0.
REQ-034 The bench SHALL cover: stream "ab" -> out_hv = 0, out_count = 0, out_valid asserted.
REQ-035 The bench SHALL cover: "abc" with in_valid toggled every other cycle, then out_ready held 0 for 5 cycles -> result identical to REQ-032 and held stable; IDLE is entered only after out_ready=1.
REQ-036 The bench SHALL cover: reset pulsed after 'b' of "abcd", then start and "abc" -> result identical to REQ-032 with no carry-over.
REQ-037 The bench SHALL cover: 200 consecutive 'a' characters -> out_count = 198, out_hv = rotl(SEED,99) ^ rotl(SEED,98) ^ rotl(SEED,97); start pulsed during ACCUM is ignored.
